// File: rtl/pong_score_fsm.sv
// pong_score_fsm: game-flow controller and two-digit BCD score keeper for pong.
// Ports:
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_refr_tick                  one-cycle pulse per frame, paces the dwell timer
//   i_start_btn                  debounced start button (level), rising edge starts a game
//   i_p1_scored, i_p2_scored     one-cycle rally-won pulses from the graphics stage
//   o_dig3..o_dig0               player 1 tens/ones, player 2 tens/ones (BCD)
//   o_game_state                 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
//   o_graph_still                ball frozen
//   o_ball_reset                 one-cycle pulse to re-centre the ball
//   o_winner                     00 none, 01 player 1, 10 player 2, 11 draw
module pong_score_fsm #(
    parameter int WIN_SCORE   = 11,
    parameter int TIMER_TICKS = 120
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_refr_tick,
    input  logic       i_start_btn,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic [3:0] o_dig3,
    output logic [3:0] o_dig2,
    output logic [3:0] o_dig1,
    output logic [3:0] o_dig0,
    output logic [1:0] o_game_state,
    output logic       o_graph_still,
    output logic       o_ball_reset,
    output logic [1:0] o_winner
);
    typedef enum logic [1:0] {NEWGAME = 2'd0, PLAY = 2'd1, NEWBALL = 2'd2, OVER = 2'd3} state_t;

    localparam logic [7:0] TICKS = 8'(TIMER_TICKS);
    localparam logic [6:0] WIN   = 7'(WIN_SCORE);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt, w_p1_inc, w_p2_inc;
    logic [7:0] r_timer, w_timer_nxt;
    logic [1:0] r_winner, w_winner_nxt;
    logic       r_graph_still, r_ball_reset, w_ball_reset_nxt, r_start_prev;
    logic       w_start_rise, w_p1_win, w_p2_win;

    // BCD pair increment {tens, ones}, 99 wraps to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? ((v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_val(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    always_comb begin
        w_start_rise     = i_start_btn & ~r_start_prev;
        w_p1_inc         = i_p1_scored ? bcd_inc(r_p1) : r_p1;
        w_p2_inc         = i_p2_scored ? bcd_inc(r_p2) : r_p2;
        w_p1_win         = bcd_val(w_p1_inc) == WIN;
        w_p2_win         = bcd_val(w_p2_inc) == WIN;
        w_state_nxt      = r_state;
        w_p1_nxt         = r_p1;
        w_p2_nxt         = r_p2;
        w_timer_nxt      = r_timer;
        w_winner_nxt     = r_winner;
        w_ball_reset_nxt = 1'b0;
        case (r_state)
            NEWGAME: if (w_start_rise) begin
                w_p1_nxt         = 8'h00;
                w_p2_nxt         = 8'h00;
                w_winner_nxt     = 2'b00;
                w_ball_reset_nxt = 1'b1;
                w_state_nxt      = PLAY;
            end
            PLAY: if (i_p1_scored | i_p2_scored) begin
                // win test uses the post-increment score of this same cycle
                w_p1_nxt    = w_p1_inc;
                w_p2_nxt    = w_p2_inc;
                w_timer_nxt = TICKS;
                if (w_p1_win | w_p2_win) begin
                    w_winner_nxt = {w_p2_win, w_p1_win};
                    w_state_nxt  = OVER;
                end else begin
                    w_state_nxt = NEWBALL;
                end
            end
            NEWBALL: if (r_timer == 8'd0) begin
                w_ball_reset_nxt = 1'b1;
                w_state_nxt      = PLAY;
            end else if (i_refr_tick) begin
                w_timer_nxt = r_timer - 8'd1;
            end
            OVER: if (r_timer == 8'd0) begin
                w_state_nxt = NEWGAME;
            end else if (i_refr_tick) begin
                w_timer_nxt = r_timer - 8'd1;
            end
        endcase
    end

    // start_prev resets high so a button held through reset is not seen as an edge
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= NEWGAME;
            r_p1          <= 8'h00;
            r_p2          <= 8'h00;
            r_timer       <= 8'd0;
            r_winner      <= 2'b00;
            r_graph_still <= 1'b1;
            r_ball_reset  <= 1'b0;
            r_start_prev  <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_p1          <= w_p1_nxt;
            r_p2          <= w_p2_nxt;
            r_timer       <= w_timer_nxt;
            r_winner      <= w_winner_nxt;
            r_graph_still <= w_state_nxt != PLAY;
            r_ball_reset  <= w_ball_reset_nxt;
            r_start_prev  <= i_start_btn;
        end
    end

    assign o_dig3        = r_p1[7:4];
    assign o_dig2        = r_p1[3:0];
    assign o_dig1        = r_p2[7:4];
    assign o_dig0        = r_p2[3:0];
    assign o_game_state  = r_state;
    assign o_graph_still = r_graph_still;
    assign o_ball_reset  = r_ball_reset;
    assign o_winner      = r_winner;
endmodule

// File: doc/pong_score_fsm.md
# pong_score_fsm

Game-flow controller and score keeper for the pong display path, sitting directly upstream of the text overlay stage. It takes miss/score pulses from the graphics stage, a start button and the 60 Hz refresh tick; it keeps two-digit BCD scores for both players and sequences the game through new-game, play, new-ball and game-over phases. Its `dig3..dig0` outputs drive the score digits of the text overlay. Its `graph_still` and `ball_reset` outputs freeze and re-centre the ball in the graphics stage.

## Interface
- `WIN_SCORE`, 11: decimal score (1..99) that ends the game.
- `TIMER_TICKS`, 120: refresh ticks spent in NEWBALL and OVER (2 s at 60 Hz). Range 1..255.
- `clk` in 1: system clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `refr_tick` in 1: one-cycle pulse per frame (60 Hz).
- `start_btn` in 1: debounced start button, level.
- `p1_scored` in 1: one-cycle pulse; player 1 wins the rally.
- `p2_scored` in 1: one-cycle pulse; player 2 wins the rally.
- `dig3` out 4: player 1 tens, BCD.
- `dig2` out 4: player 1 ones, BCD.
- `dig1` out 4: player 2 tens, BCD.
- `dig0` out 4: player 2 ones, BCD.
- `game_state` out 2: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.
- `graph_still` out 1: 1 means the ball is frozen.
- `ball_reset` out 1: one-cycle pulse meaning "re-centre the ball".
- `winner` out 2: 00 none, 01 player 1, 10 player 2, 11 draw.

## Operation
- **Start edge detection:** `start_rise = start_btn & ~start_prev`. `start_prev` is registered every cycle.
- **NEWGAME:**
  - `graph_still`=1.
  - On `start_rise`: clear all four digits and `winner`, pulse `ball_reset`, go to PLAY.
  - Score pulses are ignored.
- **PLAY:**
  - `graph_still`=0.
  - A `pN_scored` pulse increments that player's BCD pair: ones 9→0 with tens+1; 99→00 wrap (unreachable for legal `WIN_SCORE`).
  - Both pulses in the same cycle increment both pairs.
  - After the increment, if any player's value (tens·10+ones) equals `WIN_SCORE`: set `winner` (both reaching it gives 11), load the timer, go to OVER.
  - Otherwise load the timer and go to NEWBALL.
  - `start_btn` is ignored.
- **NEWBALL:**
  - `graph_still`=1.
  - The timer decrements on `refr_tick` while non-zero.
  - When the timer is 0: pulse `ball_reset`, go to PLAY.
  - Score pulses are ignored.
- **OVER:**
  - `graph_still`=1.
  - The timer decrements on `refr_tick`.
  - When the timer is 0: go to NEWGAME. Scores and `winner` are held, so the final score stays visible until the next start.
  - `start_btn` is ignored.
- The win comparison uses the post-increment value computed in the same cycle. There is no extra state.

## Timing
- **Reset values** (all outputs and state, asynchronous):
  - state NEWGAME; `dig3..dig0`=0; `winner`=00; timer=0.
  - `graph_still`=1; `ball_reset`=0.
  - `start_prev`=1, so a button held through reset does not start a game.
- All outputs are registered.
- A score pulse in cycle N produces:
  - updated digits and new `game_state` visible in cycle N+1;
  - `graph_still`=1 in cycle N+1.
- `start_rise` in cycle N produces PLAY, `ball_reset`=1 and cleared digits in cycle N+1. `ball_reset` returns to 0 in N+2.
- **NEWBALL dwell:** the timer is loaded to `TIMER_TICKS` on entry and counts one step per `refr_tick`. The exit to PLAY happens in the cycle after the timer reads 0. `ball_reset` is high for exactly that one cycle.
- A `refr_tick` coinciding with the entry cycle does not decrement: the load wins.
- Reset asserted mid-game returns to NEWGAME immediately, with scores cleared.

## Test plan
- **Reset, then start:**
  - Release reset with `start_btn`=1 → state stays 0.
  - Drop and re-raise `start_btn` → next cycle `game_state`=1, `ball_reset` pulses once, `graph_still`=0.
- **BCD carry:**
  - From 09 for player 1, pulse `p1_scored` → `dig3`=1, `dig2`=0.
  - State goes to 2; after 120 `refr_tick`s → state 1, with one `ball_reset` pulse.
- **Win:**
  - Player 2 at 10 (`WIN_SCORE`=11), pulse `p2_scored` → `dig1`=1, `dig0`=1, state 3, `winner`=10.
  - After 120 ticks → state 0 with digits still 11.
- **Simultaneous scores:**
  - Both at 10, pulse `p1_scored` and `p2_scored` in the same cycle → both show 11, state 3, `winner`=11.
- **Ignored inputs:**
  - Score pulses during NEWBALL/NEWGAME/OVER → digits unchanged.
  - `start_btn` edge during PLAY → no state change.
- **Mid-game reset:**
  - Assert `reset_n`=0 in NEWBALL with scores 05:07 → same-cycle digits 0, state 0, `graph_still`=1.
